seq_match_monitor: RTL and testbench

//  Downstream consumer of the sequence-detector match pulse (1-bit Mealy output, one pulse per match).

---
 rtl/seq_match_monitor.sv | 117 +++++++++++
 tb/tb_seq_match_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_monitor.sv
// Match-pulse monitor: saturating lifetime count plus tumbling-window threshold alarm.
// Define SEQ_MON_STICKY_ALARM_EN to keep alarm set until clr or reset.
module seq_match_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3,
  parameter int WIN_W   = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clr,
  input  logic             det_in,
  output logic [CNT_W-1:0] total_cnt,
  output logic             overflow,
  output logic [WIN_W-1:0] win_cnt,
  output logic             window_done,
  output logic             alarm,
  output logic             alarm_pulse
);

  localparam int IDX_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);
  localparam logic [WIN_W:0]   THRESH_V = (WIN_W + 1)'(THRESH);

  typedef enum logic {
    IDLE = 1'b0,
    MON  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cyc_idx, idx_nxt, idx_cur;
  logic [WIN_W-1:0] win_nxt, win_cur;
  logic [CNT_W-1:0] total_nxt;
  logic             ovf_nxt;
  logic             alarm_nxt;
  logic             done_nxt;
  logic             pulse_nxt;
  logic [WIN_W:0]   eval;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cyc_idx     <= '0;
      total_cnt   <= '0;
      overflow    <= 1'b0;
      win_cnt     <= '0;
      window_done <= 1'b0;
      alarm       <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cyc_idx     <= idx_nxt;
      total_cnt   <= total_nxt;
      overflow    <= ovf_nxt;
      win_cnt     <= win_nxt;
      window_done <= done_nxt;
      alarm       <= alarm_nxt;
      alarm_pulse <= pulse_nxt;
    end
  end

  // An edge with enable high is a monitored cycle; the edge leaving IDLE is cycle 0
  // of a fresh window, so position and count are taken as zero coming out of IDLE.
  always_comb begin
    state_nxt = enable ? MON : IDLE;
    idx_nxt   = cyc_idx;
    total_nxt = total_cnt;
    ovf_nxt   = overflow;
    win_nxt   = win_cnt;
    alarm_nxt = alarm;
    done_nxt  = 1'b0;
    pulse_nxt = 1'b0;
    idx_cur   = (state == IDLE) ? '0 : cyc_idx;
    win_cur   = (state == IDLE) ? '0 : win_cnt;
    eval      = {1'b0, win_cur} + (WIN_W + 1)'(det_in);

    if (clr) begin
      total_nxt = '0;
      ovf_nxt   = 1'b0;
      win_nxt   = '0;
      idx_nxt   = '0;
      alarm_nxt = 1'b0;
    end else if (!enable) begin
      win_nxt = '0;
      idx_nxt = '0;
    end else begin
      if (det_in) begin
        if (total_cnt == '1) begin
          ovf_nxt = 1'b1;
        end else begin
          total_nxt = total_cnt + 1'b1;
        end
      end

      if (idx_cur == LAST_IDX) begin
        win_nxt  = '0;
        idx_nxt  = '0;
        done_nxt = 1'b1;
        if (eval >= THRESH_V) begin
          alarm_nxt = 1'b1;
          pulse_nxt = ~alarm;
        end else begin
`ifdef SEQ_MON_STICKY_ALARM_EN
          alarm_nxt = alarm;
`else
          alarm_nxt = 1'b0;
`endif
        end
      end else begin
        win_nxt = eval[WIN_W-1:0];
        idx_nxt = idx_cur + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Self-checking bench for seq_match_monitor: directed scenarios plus randomized traffic
// compared every cycle against a window-level reference model.
module tb_seq_match_monitor;

  localparam int CNT_W   = 8;
  localparam int WIN_LEN = 16;
  localparam int THRESH  = 3;
  localparam int WIN_W   = 5;
  localparam int MAXCNT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             clr = 1'b0;
  logic             det_in = 1'b0;
  logic [CNT_W-1:0] total_cnt;
  logic             overflow;
  logic [WIN_W-1:0] win_cnt;
  logic             window_done;
  logic             alarm;
  logic             alarm_pulse;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Reference model state: plain integers over enabled cycles.
  int m_total, m_win, m_pos;
  bit m_ovf, m_done, m_alarm, m_pulse;

  seq_match_monitor #(
    .CNT_W  (CNT_W),
    .WIN_LEN(WIN_LEN),
    .THRESH (THRESH),
    .WIN_W  (WIN_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clr        (clr),
    .det_in     (det_in),
    .total_cnt  (total_cnt),
    .overflow   (overflow),
    .win_cnt    (win_cnt),
    .window_done(window_done),
    .alarm      (alarm),
    .alarm_pulse(alarm_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_total = 0; m_win = 0; m_pos = 0;
      m_ovf = 0; m_done = 0; m_alarm = 0; m_pulse = 0;
    end else begin
      m_done  = 0;
      m_pulse = 0;
      if (clr) begin
        m_total = 0; m_win = 0; m_pos = 0; m_ovf = 0; m_alarm = 0;
      end else if (!enable) begin
        m_win = 0; m_pos = 0;
      end else begin
        if (det_in) begin
          if (m_total == MAXCNT) m_ovf = 1;
          else m_total++;
        end
        m_win += int'(det_in);
        if (m_pos == WIN_LEN - 1) begin
          m_done = 1;
          if (m_win >= THRESH) begin
            if (!m_alarm) m_pulse = 1;
            m_alarm = 1;
          end else begin
`ifndef SEQ_MON_STICKY_ALARM_EN
            m_alarm = 0;
`endif
          end
          m_win = 0;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && reset_n) begin
      chk("model_total_cnt", int'(total_cnt), m_total);
      chk("model_overflow", int'(overflow), int'(m_ovf));
      chk("model_win_cnt", int'(win_cnt), m_win);
      chk("model_window_done", int'(window_done), int'(m_done));
      chk("model_alarm", int'(alarm), int'(m_alarm));
      chk("model_alarm_pulse", int'(alarm_pulse), int'(m_pulse));
    end
  end

  // Apply inputs for one edge; returns 2 time units after that edge.
  task automatic drive(input bit en, input bit c, input bit d);
    enable = en;
    clr    = c;
    det_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_total"}, int'(total_cnt), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_win"}, int'(win_cnt), 0);
    chk({tag, "_done"}, int'(window_done), 0);
    chk({tag, "_alarm"}, int'(alarm), 0);
    chk({tag, "_pulse"}, int'(alarm_pulse), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    cmp_on = 1'b1;

    // Idle after reset
    repeat (5) drive(0, 0, 0);
    chk_all_zero("reset_idle");

    // Window with pulses at cycles 2, 5, 15
    for (int i = 0; i < WIN_LEN; i++) drive(1, 0, (i == 2 || i == 5 || i == 15));
    chk("t2_done", int'(window_done), 1);
    chk("t2_alarm", int'(alarm), 1);
    chk("t2_pulse", int'(alarm_pulse), 1);
    chk("t2_total", int'(total_cnt), 3);
    chk("t2_win", int'(win_cnt), 0);

    // Empty window following the alarm
    for (int i = 0; i < WIN_LEN; i++) begin
      drive(1, 0, 0);
      if (i == 0) chk("t2_pulse_one_cycle", int'(alarm_pulse), 0);
    end
    chk("t4_done", int'(window_done), 1);
`ifdef SEQ_MON_STICKY_ALARM_EN
    chk("t4_alarm_sticky", int'(alarm), 1);
    drive(0, 1, 0);
    chk("t4_alarm_after_clr", int'(alarm), 0);
    drive(0, 0, 0);
`else
    chk("t4_alarm_cleared", int'(alarm), 0);
`endif

    // Two pulses: below threshold
    for (int i = 0; i < WIN_LEN; i++) begin
      drive(1, 0, (i < 2));
      if (i == 1) chk("t3_win_mid", int'(win_cnt), 2);
    end
    chk("t3_done", int'(window_done), 1);
    chk("t3_alarm", int'(alarm), 0);
    chk("t3_pulse", int'(alarm_pulse), 0);

    // Enable dropped at cycle 8 with two pulses counted
    for (int i = 0; i < 8; i++) drive(1, 0, (i < 2));
    chk("t6_win_before_drop", int'(win_cnt), 2);
    drive(0, 0, 1);
    chk("t6_drop_win", int'(win_cnt), 0);
    chk("t6_drop_done", int'(window_done), 0);
    for (int i = 0; i < WIN_LEN - 1; i++) drive(1, 0, 0);
    chk("t6_fresh_not_closed", int'(window_done), 0);
    drive(1, 0, 0);
    chk("t6_fresh_closed", int'(window_done), 1);

    // clr with det_in high drops the match
    drive(1, 0, 1);
    drive(1, 1, 1);
    chk("t6_clr_total", int'(total_cnt), 0);
    chk("t6_clr_win", int'(win_cnt), 0);

    // Async reset mid-window
    drive(1, 0, 1);
    drive(1, 0, 1);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("t6_async_reset");
    drive(1, 0, 1);
    reset_n = 1'b1;
    drive(0, 0, 0);

    // Saturation
    drive(1, 1, 0);
    for (int i = 0; i < MAXCNT; i++) drive(1, 0, 1);
    chk("t5_sat_total", int'(total_cnt), MAXCNT);
    chk("t5_sat_no_ovf", int'(overflow), 0);
    drive(1, 0, 1);
    chk("t5_ovf_set", int'(overflow), 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 1);
    chk("t5_hold_total", int'(total_cnt), MAXCNT);
    chk("t5_hold_ovf", int'(overflow), 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < 25));
    end

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
